// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_pkg
// Description : Shared definitions for the user-mode CSR unit: CSR addresses,
//               trap cause codes, next-PC select encodings, RV32I opcodes and
//               the fixed system-instruction encodings.
//               Optional feature macro: CSR_MISALIGN_EN (enables the
//               instruction/load/store misalignment traps).
// Revision    : 1.0 - initial release
// ============================================================================
package csr_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_USTATUS  = 12'h000;
    localparam logic [11:0] CSR_UTVEC    = 12'h005;
    localparam logic [11:0] CSR_USCRATCH = 12'h040;
    localparam logic [11:0] CSR_UEPC     = 12'h041;
    localparam logic [11:0] CSR_UCAUSE   = 12'h042;
    localparam logic [11:0] CSR_UTVAL    = 12'h043;

    // ustatus bit positions
    localparam int USTATUS_UIE_BIT  = 0;
    localparam int USTATUS_UPIE_BIT = 4;

    // Trap cause codes
    localparam int CAUSE_W = 4;
    localparam logic [CAUSE_W-1:0] CAUSE_INSTR_MISALIGN = 4'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL        = 4'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_BREAKPOINT     = 4'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [CAUSE_W-1:0] CAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL          = 4'd8;

    // Next-PC select
    typedef enum logic [1:0] {
        OPM_SEQ  = 2'b00,
        OPM_TRAP = 2'b01,
        OPM_RET  = 2'b10
    } opm_e;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Fixed system instruction encodings
    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_URET   = 32'h0020_0073;

    function automatic logic is_rv32i_opcode(input logic [6:0] opc);
        logic v_ok;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP,
            OPC_MISC_MEM, OPC_SYSTEM: v_ok = 1'b1;
            default:                  v_ok = 1'b0;
        endcase
        return v_ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_trap_detect.sv
`default_nettype none
// ============================================================================
// Module      : csr_trap_detect
// Description : Combinational trap decoder. Flags a trap request with its
//               cause code (highest priority first: instruction misaligned,
//               illegal opcode, ebreak, load misaligned, store misaligned,
//               ecall) and separately flags uret.
//               Optional feature macro: CSR_MISALIGN_EN. When undefined the
//               three misalignment conditions never fire.
// Ports       : instr    in  32  current instruction
//               ram_addr in  16  load/store byte address
//               rom_addr in  16  PC of current instruction
//               trap     out  1  trap requested (before UIE gating)
//               cause    out  4  cause code of the requested trap
//               is_uret  out  1  instruction is uret
// Revision    : 1.0 - initial release
// ============================================================================
module csr_trap_detect
    import csr_pkg::*;
(
    input  logic [31:0]        instr,
    input  logic [15:0]        ram_addr,
    input  logic [15:0]        rom_addr,
    output logic               trap,
    output logic [CAUSE_W-1:0] cause,
    output logic               is_uret
);

    logic [6:0] w_opcode;
    logic       w_illegal;
    logic       w_instr_mis;
    logic       w_load_mis;
    logic       w_store_mis;

    assign w_opcode  = instr[6:0];
    assign w_illegal = ~is_rv32i_opcode(w_opcode);
    assign is_uret   = (instr == INSTR_URET);

`ifdef CSR_MISALIGN_EN
    // funct3[1:0]: 00 byte, 01 half, 10 word. Byte accesses never misalign.
    logic [1:0] w_size;
    logic       w_ls_mis;

    assign w_size      = instr[13:12];
    assign w_ls_mis    = ((w_size == 2'b10) && (ram_addr[1:0] != 2'b00)) ||
                         ((w_size == 2'b01) && ram_addr[0]);
    assign w_instr_mis = (rom_addr[1:0] != 2'b00);
    assign w_load_mis  = (w_opcode == OPC_LOAD)  && w_ls_mis;
    assign w_store_mis = (w_opcode == OPC_STORE) && w_ls_mis;
`else
    logic w_unused_addr;

    assign w_unused_addr = ^{ram_addr, rom_addr};
    assign w_instr_mis   = 1'b0;
    assign w_load_mis    = 1'b0;
    assign w_store_mis   = 1'b0;
`endif

    always_comb begin
        trap  = 1'b1;
        cause = CAUSE_ECALL;
        if (w_instr_mis) begin
            cause = CAUSE_INSTR_MISALIGN;
        end else if (w_illegal) begin
            cause = CAUSE_ILLEGAL;
        end else if (instr == INSTR_EBREAK) begin
            cause = CAUSE_BREAKPOINT;
        end else if (w_load_mis) begin
            cause = CAUSE_LOAD_MISALIGN;
        end else if (w_store_mis) begin
            cause = CAUSE_STORE_MISALIGN;
        end else if (instr == INSTR_ECALL) begin
            cause = CAUSE_ECALL;
        end else begin
            trap  = 1'b0;
            cause = '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : csr_unit
// Description : User-mode CSR file (ustatus, utvec, uscratch, uepc, ucause,
//               utval) with trap entry and uret handling. Produces the
//               next-PC select and redirect target for the fetch stage.
//               Optional feature macro: CSR_MISALIGN_EN (misalignment traps).
// Ports       : clk      in   1  clock, rising edge
//               rst      in   1  synchronous reset, active high
//               instr    in  32  current instruction
//               ram_addr in  16  load/store byte address
//               rom_addr in  16  PC of current instruction
//               csr_w    in   1  CSR write enable
//               csr      in  12  CSR address
//               wd       in  32  merged CSR write data
//               rd       out 32  read data of CSR[csr] (pre-write value)
//               op_m     out  2  00 sequential, 01 trap, 10 return
//               addr_o   out 32  redirect target
// Revision    : 1.0 - initial release
// ============================================================================
module csr_unit
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [15:0] ram_addr,
    input  logic [15:0] rom_addr,
    input  logic        csr_w,
    input  logic [11:0] csr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [1:0]  op_m,
    output logic [31:0] addr_o
);

    // CSR state. ustatus keeps only its two implemented bits.
    logic        r_uie;
    logic        r_upie;
    logic [31:0] r_utvec;
    logic [31:0] r_uscratch;
    logic [31:0] r_uepc;
    logic [31:0] r_ucause;
    logic [31:0] r_utval;

    logic               w_trap_req;
    logic [CAUSE_W-1:0] w_cause;
    logic               w_is_uret;
    logic               w_take_trap;
    logic               w_take_ret;
    logic [31:0]        w_tval;

    csr_trap_detect u_trap_detect (
        .instr    (instr),
        .ram_addr (ram_addr),
        .rom_addr (rom_addr),
        .trap     (w_trap_req),
        .cause    (w_cause),
        .is_uret  (w_is_uret)
    );

    // Traps are only taken with interrupts-enabled; uret is never a trap
    // source itself, but an instruction-misaligned uret traps instead.
    assign w_take_trap = w_trap_req & r_uie;
    assign w_take_ret  = w_is_uret & ~w_take_trap;

    always_comb begin
        case (w_cause)
            CAUSE_INSTR_MISALIGN: w_tval = {16'd0, rom_addr};
            CAUSE_ILLEGAL:        w_tval = instr;
            CAUSE_LOAD_MISALIGN,
            CAUSE_STORE_MISALIGN: w_tval = {16'd0, ram_addr};
            default:              w_tval = 32'd0;
        endcase
    end

    // Read path: stored value only, a same-cycle write is not forwarded.
    always_comb begin
        case (csr)
            CSR_USTATUS:  rd = {27'd0, r_upie, 3'd0, r_uie};
            CSR_UTVEC:    rd = r_utvec;
            CSR_USCRATCH: rd = r_uscratch;
            CSR_UEPC:     rd = r_uepc;
            CSR_UCAUSE:   rd = r_ucause;
            CSR_UTVAL:    rd = r_utval;
            default:      rd = 32'd0;
        endcase
    end

    always_comb begin
        op_m   = OPM_SEQ;
        addr_o = 32'd0;
        if (w_take_trap) begin
            op_m   = OPM_TRAP;
            addr_o = {r_utvec[31:2], 2'b00};
        end else if (w_take_ret) begin
            op_m   = OPM_RET;
            addr_o = r_uepc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_uie      <= 1'b0;
            r_upie     <= 1'b0;
            r_utvec    <= 32'd0;
            r_uscratch <= 32'd0;
            r_uepc     <= 32'd0;
            r_ucause   <= 32'd0;
            r_utval    <= 32'd0;
        end else begin
            if (csr_w && !w_take_trap) begin
                case (csr)
                    CSR_USTATUS: begin
                        r_uie  <= wd[USTATUS_UIE_BIT];
                        r_upie <= wd[USTATUS_UPIE_BIT];
                    end
                    CSR_UTVEC:    r_utvec    <= wd;
                    CSR_USCRATCH: r_uscratch <= wd;
                    CSR_UEPC:     r_uepc     <= wd;
                    CSR_UCAUSE:   r_ucause   <= wd;
                    CSR_UTVAL:    r_utval    <= wd;
                    default: ;
                endcase
            end
            // Trap/return updates follow the CSR write so they take
            // precedence on ustatus if both occur in one cycle.
            if (w_take_trap) begin
                r_uepc   <= {16'd0, rom_addr};
                r_ucause <= {{(32-CAUSE_W){1'b0}}, w_cause};
                r_utval  <= w_tval;
                r_upie   <= r_uie;
                r_uie    <= 1'b0;
            end else if (w_take_ret) begin
                r_uie  <= r_upie;
                r_upie <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_unit
// Description : Self-checking bench for csr_unit. A table of stimulus
//               records with expected outputs is applied one per cycle;
//               expectations are queued when driven and compared once the
//               combinational outputs settle. Hand-written sequences cover
//               reset during a trap and a back-to-back trap/uret.
//               Honours CSR_MISALIGN_EN for the misalignment expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_unit;

`ifdef CSR_MISALIGN_EN
    localparam bit M = 1'b1;
`else
    localparam bit M = 1'b0;
`endif

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] URET   = 32'h0020_0073;

    localparam logic [11:0] A_ST = 12'h000;
    localparam logic [11:0] A_TV = 12'h005;
    localparam logic [11:0] A_SC = 12'h040;
    localparam logic [11:0] A_EP = 12'h041;
    localparam logic [11:0] A_CA = 12'h042;
    localparam logic [11:0] A_TL = 12'h043;

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic [15:0] ram;
        logic [15:0] rom;
        logic        w;
        logic [11:0] csr;
        logic [31:0] wd;
        logic [1:0]  e_op;
        logic [31:0] e_addr;
        logic [31:0] e_rd;
    } vec_t;

    typedef struct {
        int          id;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] rdv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [15:0] ram_addr;
    logic [15:0] rom_addr;
    logic        csr_w;
    logic [11:0] csr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [1:0]  op_m;
    logic [31:0] addr_o;

    int n_cmp  = 0;
    int n_fail = 0;

    vec_t vecs[$];
    exp_t sb[$];

    csr_unit dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .ram_addr (ram_addr),
        .rom_addr (rom_addr),
        .csr_w    (csr_w),
        .csr      (csr),
        .wd       (wd),
        .rd       (rd),
        .op_m     (op_m),
        .addr_o   (addr_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [31:0] i,
                                input logic [15:0] ra, input logic [15:0] ro,
                                input logic w, input logic [11:0] c,
                                input logic [31:0] d, input logic [1:0] eop,
                                input logic [31:0] eaddr, input logic [31:0] erd);
        vec_t v;
        v.rst = r; v.instr = i; v.ram = ra; v.rom = ro; v.w = w; v.csr = c;
        v.wd = d; v.e_op = eop; v.e_addr = eaddr; v.e_rd = erd;
        return v;
    endfunction

    // Read a CSR with a harmless instruction in flight.
    function automatic void rdv(input logic [11:0] c, input logic [31:0] erd);
        vecs.push_back(mk(1'b0, NOP, 16'd0, 16'd0, 1'b0, c, 32'd0, 2'b00, 32'd0, erd));
    endfunction

    // Write a CSR; erd is the value before the write.
    function automatic void wrv(input logic [11:0] c, input logic [31:0] d,
                                input logic [31:0] erd);
        vecs.push_back(mk(1'b0, NOP, 16'd0, 16'd0, 1'b1, c, d, 2'b00, 32'd0, erd));
    endfunction

    // Execute an instruction while reading CSR c.
    function automatic void exv(input logic [31:0] i, input logic [15:0] ra,
                                input logic [15:0] ro, input logic [11:0] c,
                                input logic [1:0] eop, input logic [31:0] eaddr,
                                input logic [31:0] erd);
        vecs.push_back(mk(1'b0, i, ra, ro, 1'b0, c, 32'd0, eop, eaddr, erd));
    endfunction

    task automatic check_one();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard: empty queue, got nothing want an entry");
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (op_m !== e.op) begin
                n_fail++;
                $display("FAIL v%0d op_m: got %b want %b", e.id, op_m, e.op);
            end
            n_cmp++;
            if (addr_o !== e.addr) begin
                n_fail++;
                $display("FAIL v%0d addr_o: got %h want %h", e.id, addr_o, e.addr);
            end
            n_cmp++;
            if (rd !== e.rdv) begin
                n_fail++;
                $display("FAIL v%0d rd(csr=%h): got %h want %h", e.id, csr, rd, e.rdv);
            end
        end
    endtask

    task automatic apply(input vec_t v, input int id);
        exp_t e;
        @(negedge clk);
        rst = v.rst; instr = v.instr; ram_addr = v.ram; rom_addr = v.rom;
        csr_w = v.w; csr = v.csr; wd = v.wd;
        e.id = id; e.op = v.e_op; e.addr = v.e_addr; e.rdv = v.e_rd;
        sb.push_back(e);
        #2;
        check_one();
    endtask

    initial begin
        rst = 1'b1; instr = NOP; ram_addr = '0; rom_addr = '0;
        csr_w = 1'b0; csr = '0; wd = '0;
        repeat (2) @(posedge clk);

        // ---------------- main table ----------------
        rdv(A_ST, 32'h0);                                   // reset state
        rdv(A_TV, 32'h0);
        wrv(A_TV, 32'h100, 32'h0);                          // no bypass
        rdv(A_TV, 32'h100);
        wrv(A_ST, 32'h1, 32'h0);
        rdv(A_ST, 32'h1);
        exv(32'hfff0_2003, 16'hFFFF, 16'd12, A_ST,          // misaligned lw
            M ? 2'b01 : 2'b00, M ? 32'h100 : 32'h0, 32'h1);
        rdv(A_EP, M ? 32'd12 : 32'd0);
        rdv(A_CA, M ? 32'd4 : 32'd0);
        rdv(A_TL, M ? 32'hFFFF : 32'd0);
        rdv(A_ST, M ? 32'h10 : 32'h1);
        exv(32'h00a0_0893, 16'd32, 16'd16, A_ST,            // normal addi
            2'b00, 32'h0, M ? 32'h10 : 32'h1);
        rdv(A_ST, M ? 32'h10 : 32'h1);
        rdv(A_EP, M ? 32'd12 : 32'd0);
        exv(URET, 16'd0, 16'd20, A_ST, 2'b10, M ? 32'd12 : 32'd0,
            M ? 32'h10 : 32'h1);
        rdv(A_ST, M ? 32'h11 : 32'h10);
        wrv(A_ST, 32'h11, M ? 32'h11 : 32'h10);
        rdv(A_ST, 32'h11);
        // illegal opcode with a simultaneous write that must be dropped
        vecs.push_back(mk(1'b0, 32'hDEAD_BEFF, 16'd0, 16'h40, 1'b1, A_SC,
                          32'h55, 2'b01, 32'h100, 32'h0));
        rdv(A_SC, 32'h0);
        rdv(A_CA, 32'd2);
        rdv(A_TL, 32'hDEAD_BEFF);
        rdv(A_EP, 32'h40);
        rdv(A_ST, 32'h10);
        exv(ECALL, 16'd0, 16'h7C, A_CA, 2'b00, 32'h0, 32'd2); // UIE=0: no trap
        rdv(A_CA, 32'd2);
        wrv(A_ST, 32'h1, 32'h10);
        exv(ECALL, 16'd0, 16'h80, A_ST, 2'b01, 32'h100, 32'h1);
        rdv(A_CA, 32'd8);
        rdv(A_TL, 32'd0);
        rdv(A_EP, 32'h80);
        rdv(A_ST, 32'h10);
        wrv(A_SC, 32'hCAFE_BABE, 32'h0);
        rdv(A_SC, 32'hCAFE_BABE);
        wrv(12'h123, 32'hFFFF_FFFF, 32'h0);                 // unimplemented
        rdv(12'h123, 32'h0);
        wrv(A_ST, 32'hFFFF_FFFF, 32'h10);
        rdv(A_ST, 32'h11);
        exv(EBREAK, 16'd0, 16'h84, A_ST, 2'b01, 32'h100, 32'h11);
        rdv(A_CA, 32'd3);
        wrv(A_TV, 32'h203, 32'h100);
        rdv(A_TV, 32'h203);
        wrv(A_ST, 32'h1, 32'h10);
        exv(ECALL, 16'd0, 16'h88, A_ST, 2'b01, 32'h200, 32'h1); // low bits masked
        wrv(A_ST, 32'h1, 32'h10);
        exv(NOP, 16'd0, 16'h102, A_ST,                      // misaligned PC
            M ? 2'b01 : 2'b00, M ? 32'h200 : 32'h0, 32'h1);
        rdv(A_CA, M ? 32'd0 : 32'd8);
        rdv(A_TL, M ? 32'h102 : 32'd0);
        rdv(A_EP, M ? 32'h102 : 32'h88);
        wrv(A_ST, 32'h1, M ? 32'h10 : 32'h1);
        exv(32'h0000_1023, 16'h1, 16'h8C, A_ST,             // misaligned sh
            M ? 2'b01 : 2'b00, M ? 32'h200 : 32'h0, 32'h1);
        rdv(A_CA, M ? 32'd6 : 32'd8);
        rdv(A_TL, M ? 32'h1 : 32'd0);
        wrv(A_ST, 32'h1, M ? 32'h10 : 32'h1);
        exv(32'h0000_0003, 16'h3, 16'h90, A_ST, 2'b00, 32'h0, 32'h1); // lb: ok
        exv(32'h0000_2003, 16'h4, 16'h94, A_ST, 2'b00, 32'h0, 32'h1); // aligned lw
        exv(32'h0000_5003, 16'h2, 16'h98, A_ST, 2'b00, 32'h0, 32'h1); // aligned lhu

        for (int k = 0; k < vecs.size(); k++) begin
            apply(vecs[k], k);
        end

        // ------- reset wins over a simultaneous trap and write -------
        // UIE=1, utvec=0x203 here; the trap shows combinationally but
        // the edge must only clear.
        apply(mk(1'b1, ECALL, 16'd0, 16'hA0, 1'b1, A_TV, 32'h999,
                 2'b01, 32'h200, 32'h203), 100);
        apply(mk(1'b0, ECALL, 16'd0, 16'hA4, 1'b0, A_ST, 32'h0,
                 2'b00, 32'h0, 32'h0), 101);
        apply(mk(1'b0, NOP, 16'd0, 16'd0, 1'b0, A_TV, 32'h0, 2'b00, 32'h0, 32'h0), 102);
        apply(mk(1'b0, NOP, 16'd0, 16'd0, 1'b0, A_EP, 32'h0, 2'b00, 32'h0, 32'h0), 103);
        apply(mk(1'b0, NOP, 16'd0, 16'd0, 1'b0, A_CA, 32'h0, 2'b00, 32'h0, 32'h0), 104);
        apply(mk(1'b0, NOP, 16'd0, 16'd0, 1'b0, A_TL, 32'h0, 2'b00, 32'h0, 32'h0), 105);
        apply(mk(1'b0, NOP, 16'd0, 16'd0, 1'b0, A_SC, 32'h0, 2'b00, 32'h0, 32'h0), 106);

        // ------- back-to-back trap then uret -------
        apply(mk(1'b0, NOP, 16'd0, 16'd0, 1'b1, A_TV, 32'h300, 2'b00, 32'h0, 32'h0), 110);
        apply(mk(1'b0, NOP, 16'd0, 16'd0, 1'b1, A_ST, 32'h1, 2'b00, 32'h0, 32'h0), 111);
        apply(mk(1'b0, ECALL, 16'd0, 16'h44, 1'b0, A_ST, 32'h0,
                 2'b01, 32'h300, 32'h1), 112);
        apply(mk(1'b0, URET, 16'd0, 16'h300, 1'b0, A_ST, 32'h0,
                 2'b10, 32'h44, 32'h10), 113);
        apply(mk(1'b0, NOP, 16'd0, 16'h44, 1'b0, A_ST, 32'h0,
                 2'b00, 32'h0, 32'h11), 114);

        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 clk  input  1  clock; all CSR state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous reset, active high.
REQ-004 instr  input  32  instruction currently executing.
REQ-005 ram_addr  input  16  data-memory byte address of the current load/store.
REQ-006 rom_addr  input  16  PC of the current instruction.
REQ-007 csr_w  input  1  CSR write enable from the CSR instruction path.
REQ-008 csr  input  12  CSR address, equal to instr[31:20].
REQ-009 wd  input  32  CSR write data, already merged for csrrw/csrrs/csrrc and their immediate forms.
REQ-010 rd  output  32  combinational read data of the addressed CSR.
REQ-011 op_m  output  2  next-PC select: 00 sequential, 01 trap, 10 return.
REQ-012 addr_o  output  32  redirect target for op_m.

Function
REQ-013 The block SHALL implement these user CSRs, 32 bits each:
- ustatus 0x000: bit0 UIE, bit4 UPIE; all other bits read 0.
- utvec 0x005
- uscratch 0x040
- uepc 0x041
- ucause 0x042
- utval 0x043
REQ-014 Reads of an unimplemented CSR address SHALL return 0, and writes to one SHALL be ignored.
REQ-015 rd SHALL equal the stored value of CSR[csr] combinationally, with no bypass of a same-cycle write.
REQ-016 When csr_w=1 and no trap is taken, CSR[csr] SHALL load wd at the clock edge.
REQ-017 The block SHALL detect traps combinationally, in this priority order:
- instruction misaligned: rom_addr[1:0]!=0, cause 0.
- illegal opcode: instr[6:0] not an RV32I opcode, cause 2.
- ebreak: instr=0x00100073, cause 3.
- load misaligned, cause 4.
- store misaligned, cause 6.
- ecall: instr=0x00000073, cause 8.
REQ-018 A load (opcode 0000011) or store (opcode 0100011) SHALL be misaligned under these conditions:
- lw/sw: ram_addr[1:0]!=0.
- lh/lhu/sh: ram_addr[0]!=0.
- byte accesses: never misaligned.
REQ-019 A trap SHALL be taken only when ustatus.UIE=1; when UIE=0 the instruction SHALL proceed with op_m=00.
REQ-020 When a trap is taken, the outputs SHALL be op_m=01 and addr_o={utvec[31:2],2'b00}.
REQ-021 When a trap is taken, the block SHALL update at the edge:
- uepc <= zero-extended rom_addr.
- ucause <= cause code.
- utval <= zero-extended ram_addr for a misaligned load/store, zero-extended rom_addr for instruction misaligned, instr for illegal, 0 otherwise.
- UPIE <= UIE, UIE <= 0.
REQ-022 A trap taken in the same cycle as csr_w=1 SHALL suppress the csr_w write.
REQ-023 uret (instr=0x00200073) SHALL drive op_m=10 and addr_o=uepc, and at the edge set UIE<=UPIE and UPIE<=1.
REQ-024 Otherwise the block SHALL drive op_m=00 and addr_o=0.
REQ-025 The encoding op_m=11 SHALL never be driven.

Reset
REQ-026 When rst=1 at a clock edge, all CSRs SHALL clear to 0.
REQ-027 While rst=1, the trap and uret state updates SHALL be suppressed, so reset wins over every simultaneous event.
REQ-028 The combinational outputs SHALL follow the reset state on the cycle after the reset edge.

Configuration
REQ-029 With CSR_MISALIGN_EN defined, the load, store and instruction misalignment traps SHALL be detected.
REQ-030 Without CSR_MISALIGN_EN, those misalignment conditions SHALL never trap, and all other behaviour SHALL be unchanged.

Structure
REQ-031 A shared package csr_pkg SHALL hold the CSR address constants, the cause-code constants and the op_m encodings (OPM_SEQ, OPM_TRAP, OPM_RET).
REQ-032 The combinational trap decoder SHALL be a single sub-module, csr_trap_detect (inputs instr, ram_addr, rom_addr; outputs trap, cause, is_uret), instantiated once inside csr_unit.

Verification
REQ-033 Write utvec: csr=0x005, csr_w=1, wd=0x100 -> next cycle rd with csr=0x005 reads 0x00000100.
REQ-034 Set UIE: csr=0x000, csr_w=1, wd=1 (csrrsi) -> ustatus reads 0x1.
REQ-035 Misaligned load trap, with UIE=1, utvec=0x100:
- Stimulus: instr=0xfff02003, ram_addr=0xFFFF, rom_addr=12.
- Same cycle: op_m=01, addr_o=0x100.
- After the edge: uepc=12, ucause=4, utval=0xFFFF, ustatus=0x10.
REQ-036 Normal instruction: instr=0x00a00893, ram_addr=32, rom_addr=16 -> op_m=00, addr_o=0, and no CSR changes.
REQ-037 uret after REQ-035: instr=0x00200073 -> op_m=10, addr_o=12, and ustatus returns to 0x11.
REQ-038 Suppressed trap: UIE=0 with a misaligned lw -> op_m=00 and CSRs unchanged; rst=1 mid-sequence -> all CSRs read 0.
